// File: rtl/tim_apb_master_pkg.sv
// Shared types and constants for the tim_* APB requester and related APB-facing blocks.
package tim_apb_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    localparam logic [3:0] STRB_ALL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_t;

    // Cause of the last response; ERR_NONE is the only non-error code.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SLVERR  = 2'd1;
    localparam logic [1:0] ERR_ALIGN   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/tim_apb_master_if.sv
// Command/response and APB bus bundle for tim_apb_master; master = the requester, slave = its environment.
interface tim_apb_master_if #(
    parameter int ADDR_W = tim_apb_pkg::ADDR_W,
    parameter int DATA_W = tim_apb_pkg::DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_strb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              tim_psel;
    logic              tim_penable;
    logic              tim_pwrite;
    logic [ADDR_W-1:0] tim_paddr;
    logic [DATA_W-1:0] tim_pwdata;
    logic [3:0]        tim_pstrb;
    logic [DATA_W-1:0] tim_prdata;
    logic              tim_pready;
    logic              tim_pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
        input  tim_prdata, tim_pready, tim_pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
        output tim_prdata, tim_pready, tim_pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
    );

endinterface

// File: rtl/tim_apb_master_wait_timer.sv
// Saturating wait-cycle counter with clear, load and enable; flags the increment that lands on the limit.
module apb_wait_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;

    assign count_inc = (count == {WIDTH{1'b1}}) ? count : count + WIDTH'(1);

    // Combinational so the owner can leave its wait state on the same edge the limit is reached.
    assign expired = en && (limit != '0) && (count_inc == limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/tim_apb_master.sv
// APB4 requester for the timer_top tim_* port: one transfer at a time from a valid/ready command,
// returning a held response; misaligned commands and unresponsive slaves end in an error response.
module tim_apb_master #(
    parameter int ADDR_W         = tim_apb_pkg::ADDR_W,
    parameter int DATA_W         = tim_apb_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic               sys_clk,
    input logic               sys_rst,
    tim_apb_master_if.master  bus
);
    import tim_apb_pkg::*;

    localparam int              CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    apb_state_t state, state_nx;

    logic              accept;
    logic              aligned;
    logic              tmo_hit;
    logic              psel;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [3:0]        pstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        err_code_q;

    assign accept  = (state == ST_IDLE) && bus.cmd_valid;
    assign aligned = word_aligned(bus.cmd_addr[1:0]);

    // A limit of zero never expires, which is how TIMEOUT_CYCLES = 0 disables the abort.
    apb_wait_timer #(.WIDTH(CNT_W)) u_wait_timer (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .clr      (accept && aligned),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .en       ((state == ST_ACCESS) && !bus.tim_pready),
        .limit    (LIMIT),
        .expired  (tmo_hit)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (bus.cmd_valid) state_nx = aligned ? ST_SETUP : ST_RESP;
            ST_SETUP:  state_nx = ST_ACCESS;
            ST_ACCESS: if (bus.tim_pready || tmo_hit) state_nx = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pstrb_q    <= 4'b0000;
            rdata_q    <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid && aligned) begin
                        pwrite_q <= bus.cmd_write;
                        paddr_q  <= bus.cmd_addr;
                        pwdata_q <= bus.cmd_wdata;
                        pstrb_q  <= bus.cmd_write ? bus.cmd_strb : 4'b0000;
                    end else if (bus.cmd_valid) begin
                        rdata_q    <= '0;
                        err_code_q <= ERR_ALIGN;
                    end
                end
                ST_ACCESS: begin
                    // pready takes priority over a timeout reached in the same cycle.
                    if (bus.tim_pready) begin
                        rdata_q    <= (pwrite_q || bus.tim_pslverr) ? '0 : bus.tim_prdata;
                        err_code_q <= bus.tim_pslverr ? ERR_SLVERR : ERR_NONE;
                    end else if (tmo_hit) begin
                        rdata_q    <= '0;
                        err_code_q <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign psel            = (state == ST_SETUP) || (state == ST_ACCESS);
    assign bus.cmd_ready   = (state == ST_IDLE);
    assign bus.tim_psel    = psel;
    assign bus.tim_penable = (state == ST_ACCESS);
    assign bus.tim_pwrite  = pwrite_q;
    assign bus.tim_paddr   = paddr_q;
    assign bus.tim_pwdata  = pwdata_q;
    assign bus.tim_pstrb   = psel ? pstrb_q : 4'b0000;
    assign bus.rsp_valid   = (state == ST_RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = (err_code_q != ERR_NONE);
    assign bus.rsp_timeout = (err_code_q == ERR_TIMEOUT);

endmodule

// File: tb/tb_tim_apb_master.sv
// Bench for tim_apb_master: directed vector table, a reset-during-ACCESS sequence and random
// transfers checked against a transfer-level model of the requester.
module tb_tim_apb_master;

    localparam int TMO = 16;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [3:0]  st;
        int          waits;
        logic [31:0] prd;
        logic        sle;
        int          hold;
        logic        e_err;
        logic        e_tmo;
        logic [31:0] e_rdata;
        int          e_acc;
        int          e_lat;
    } vec_t;

    typedef struct {
        int          psel_k;
        int          acc_n;
        int          rsp_k;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        logic [3:0]  pstrb;
        logic [31:0] pwdata;
        logic [11:0] paddr;
        logic        pwrite;
        logic        addr_stable;
        logic        rsp_stable;
        logic        done_ok;
        logic        idle_ok;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tim_apb_master_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    tim_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transfer-level expectation: what the requester must report for one command.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        if (v.addr[1:0] != 2'b00) begin
            e.e_err = 1'b1; e.e_tmo = 1'b0; e.e_rdata = 32'h0; e.e_acc = 0; e.e_lat = 1;
        end else if (TMO != 0 && v.waits >= TMO) begin
            e.e_err = 1'b1; e.e_tmo = 1'b1; e.e_rdata = 32'h0; e.e_acc = TMO; e.e_lat = 2 + TMO;
        end else begin
            e.e_err   = v.sle;
            e.e_tmo   = 1'b0;
            e.e_rdata = (v.wr || v.sle) ? 32'h0 : v.prd;
            e.e_acc   = v.waits + 1;
            e.e_lat   = v.waits + 3;
        end
        return e;
    endfunction

    // Issues one command and plays the APB slave: pready rises in ACCESS cycle waits+1.
    task automatic run_xfer(input vec_t v, output res_t r);
        logic got = 1'b0;
        int   g = 0;
        r = '{default: 0};
        r.addr_stable = 1'b1;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wd;
        bus.cmd_strb  = v.st;
        bus.rsp_ready = 1'b0;
        for (int k = 1; k <= 100 && !got; k++) begin
            @(negedge clk);
            if (k == 1) bus.cmd_valid = 1'b0;
            if (bus.tim_psel === 1'b1 && r.psel_k == 0) begin
                r.psel_k = k;
                r.pstrb  = bus.tim_pstrb;
                r.pwdata = bus.tim_pwdata;
                r.paddr  = bus.tim_paddr;
                r.pwrite = bus.tim_pwrite;
            end
            if (bus.tim_psel === 1'b1 && bus.tim_paddr !== r.paddr) r.addr_stable = 1'b0;
            if (bus.tim_psel === 1'b1 && bus.tim_penable === 1'b1) begin
                r.acc_n++;
                if (r.acc_n > v.waits) begin
                    bus.tim_pready  = 1'b1;
                    bus.tim_prdata  = v.prd;
                    bus.tim_pslverr = v.sle;
                end else begin
                    bus.tim_pready  = 1'b0;
                    bus.tim_prdata  = $urandom;
                    bus.tim_pslverr = 1'b0;
                end
            end else begin
                bus.tim_pready  = 1'b0;
                bus.tim_pslverr = 1'b0;
            end
            if (bus.rsp_valid === 1'b1) begin
                got        = 1'b1;
                r.rsp_k    = k;
                r.rdata    = bus.rsp_rdata;
                r.err      = bus.rsp_err;
                r.tmo      = bus.rsp_timeout;
                r.rsp_stable = (bus.cmd_ready === 1'b0) && (bus.tim_psel === 1'b0);
            end
        end
        bus.tim_pready  = 1'b0;
        bus.tim_pslverr = 1'b0;
        if (got) begin
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                if (!(bus.rsp_valid === 1'b1 && bus.rsp_rdata === r.rdata && bus.rsp_err === r.err &&
                      bus.rsp_timeout === r.tmo && bus.cmd_ready === 1'b0 && bus.tim_psel === 1'b0))
                    r.rsp_stable = 1'b0;
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            r.done_ok = (bus.rsp_valid === 1'b0) && (bus.cmd_ready === 1'b1);
            r.idle_ok = (bus.tim_pstrb === 4'b0000) && (bus.tim_psel === 1'b0) &&
                        (v.addr[1:0] != 2'b00 || (bus.tim_paddr === v.addr && bus.tim_pwrite === v.wr));
        end
    endtask

    task automatic cmp(input string tag, input vec_t e, input res_t r);
        logic aligned = (e.addr[1:0] == 2'b00);
        chk({tag, ".latency"}, 64'(r.rsp_k), 64'(e.e_lat));
        chk({tag, ".rsp_err"}, 64'(r.err), 64'(e.e_err));
        chk({tag, ".rsp_timeout"}, 64'(r.tmo), 64'(e.e_tmo));
        chk({tag, ".rsp_rdata"}, 64'(r.rdata), 64'(e.e_rdata));
        chk({tag, ".access_cycles"}, 64'(r.acc_n), 64'(e.e_acc));
        chk({tag, ".psel_first"}, 64'(r.psel_k), aligned ? 64'd1 : 64'd0);
        if (aligned) begin
            chk({tag, ".pstrb"}, 64'(r.pstrb), e.wr ? 64'(e.st) : 64'd0);
            chk({tag, ".paddr"}, 64'(r.paddr), 64'(e.addr));
            chk({tag, ".pwrite"}, 64'(r.pwrite), 64'(e.wr));
            chk({tag, ".paddr_stable"}, 64'(r.addr_stable), 64'd1);
            if (e.wr) chk({tag, ".pwdata"}, 64'(r.pwdata), 64'(e.wd));
        end
        chk({tag, ".rsp_hold"}, 64'(r.rsp_stable), 64'd1);
        chk({tag, ".handshake"}, 64'(r.done_ok), 64'd1);
        chk({tag, ".idle_outputs"}, 64'(r.idle_ok), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vec_t v;
        res_t r;
        logic bad;
        int   g;

        vecs[0] = '{1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0,  32'h12345678, 1'b0, 0, 1'b0, 1'b0, 32'h0,     1,  3};
        vecs[1] = '{1'b0, 12'h010, 32'h0,        4'hF, 3,  32'h000000A5, 1'b0, 0, 1'b0, 1'b0, 32'hA5,    4,  6};
        vecs[2] = '{1'b0, 12'h0FC, 32'h0,        4'h0, 0,  32'h00000055, 1'b1, 0, 1'b1, 1'b0, 32'h0,     1,  3};
        vecs[3] = '{1'b0, 12'h020, 32'h0,        4'h0, 40, 32'h00000077, 1'b0, 0, 1'b1, 1'b1, 32'h0,     16, 18};
        vecs[4] = '{1'b1, 12'h002, 32'h00001111, 4'hF, 0,  32'h0,        1'b0, 0, 1'b1, 1'b0, 32'h0,     0,  1};
        vecs[5] = '{1'b1, 12'h008, 32'h0BADF00D, 4'h5, 2,  32'h0,        1'b0, 5, 1'b0, 1'b0, 32'h0,     3,  5};
        vecs[6] = '{1'b0, 12'h030, 32'h0,        4'h0, 15, 32'h0000CAFE, 1'b0, 1, 1'b0, 1'b0, 32'hCAFE,  16, 18};
        vecs[7] = '{1'b0, 12'h034, 32'h0,        4'h0, 16, 32'h0000BEEF, 1'b0, 0, 1'b1, 1'b1, 32'h0,     16, 18};
        vecs[8] = '{1'b1, 12'h100, 32'hFFFF0000, 4'h3, 1,  32'h00000009, 1'b1, 2, 1'b1, 1'b0, 32'h0,     2,  4};

        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.cmd_strb = '0; bus.rsp_ready = 1'b0; bus.tim_prdata = '0; bus.tim_pready = 1'b0;
        bus.tim_pslverr = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("reset.psel", 64'(bus.tim_psel), 64'd0);
        chk("reset.penable", 64'(bus.tim_penable), 64'd0);
        chk("reset.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset.pstrb", 64'(bus.tim_pstrb), 64'd0);
        chk("reset.paddr", 64'(bus.tim_paddr), 64'd0);
        chk("reset.pwdata", 64'(bus.tim_pwdata), 64'd0);
        chk("reset.pwrite", 64'(bus.tim_pwrite), 64'd0);
        chk("reset.rsp_fields", 64'({bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_xfer(vecs[i], r);
            cmp($sformatf("vec%0d", i), vecs[i], r);
        end

        // Reset while the slave stalls in ACCESS: transfer vanishes without a response.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 12'h040; bus.cmd_strb = 4'hF;
        g = 0;
        do begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            g++;
        end while (bus.tim_penable !== 1'b1 && g < 10);
        chk("rst_mid.reached_access", 64'(bus.tim_penable), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.psel", 64'(bus.tim_psel), 64'd0);
        chk("rst_mid.penable", 64'(bus.tim_penable), 64'd0);
        chk("rst_mid.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_mid.cmd_ready", 64'(bus.cmd_ready), 64'd1);
        rst = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.tim_psel !== 1'b0 || bus.cmd_ready !== 1'b1) bad = 1'b1;
        end
        chk("rst_mid.quiet_after", 64'(bad), 64'd0);

        run_xfer(vecs[0], r);
        cmp("after_reset", vecs[0], r);

        for (int i = 0; i < 40; i++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.addr  = 12'($urandom) & 12'hFFC;
            if ($urandom_range(0, 4) == 0) v.addr[1:0] = 2'($urandom_range(1, 3));
            v.wd    = $urandom;
            v.st    = 4'($urandom);
            v.waits = $urandom_range(0, 20);
            v.prd   = $urandom;
            v.sle   = ($urandom_range(0, 5) == 0);
            v.hold  = $urandom_range(0, 3);
            v = model(v);
            run_xfer(v, r);
            cmp($sformatf("rand%0d", i), v, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
